// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: predictor query, redirect, instruction memory and ID handoff.
interface instruction_fetch_unit_if;
  logic [31:0] pred_query_pc;
  logic [31:0] pred_next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  // Fetch unit side
  modport master (
    output pred_query_pc,
    input  pred_next_pc,
    input  redirect_valid,
    input  redirect_pc,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_resp_valid,
    input  imem_resp_data,
    output id_valid,
    input  id_ready,
    output id_instruction,
    output id_pc
  );

  // Environment side (predictor, EX, memory, ID)
  modport slave (
    input  pred_query_pc,
    output pred_next_pc,
    output redirect_valid,
    output redirect_pc,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_resp_valid,
    output imem_resp_data,
    input  id_valid,
    output id_ready,
    input  id_instruction,
    input  id_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, predictor-driven next PC,
// small instruction FIFO toward ID, EX redirect flushes and drains stale responses.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  instruction_fetch_unit_if.master        bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];

  logic req_valid_c;
  logic req_fire_c;
  logic id_valid_c;
  logic push_c;
  logic pop_c;

  // Handshake qualifiers; reset masks both valids
  assign req_valid_c = (state_q == S_REQ) && (count_q < DEPTH_C) && !reset;
  assign req_fire_c  = req_valid_c && bus.imem_req_ready;
  assign id_valid_c  = (count_q != '0) && !reset;
  assign push_c      = (state_q == S_WAIT) && bus.imem_resp_valid && !bus.redirect_valid && !reset;
  assign pop_c       = id_valid_c && bus.id_ready && !bus.redirect_valid;

  assign bus.pred_query_pc  = pc_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.imem_req_valid = req_valid_c;
  assign bus.id_valid       = id_valid_c;
  assign bus.id_pc          = fifo_pc_q[rd_ptr_q];
  assign bus.id_instruction = fifo_instr_q[rd_ptr_q];

  // FSM and fetch PC next-state; redirect overrides the normal path
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (req_fire_c) begin
          fetch_pc_d = pc_q;
          pc_d       = bus.pred_next_pc & PC_MASK;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (bus.imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & PC_MASK;
      if (state_q == S_REQ) begin
        // A request accepted this cycle still returns a response that must be drained
        state_d = req_fire_c ? S_DRAIN : S_REQ;
      end else begin
        state_d = bus.imem_resp_valid ? S_REQ : S_DRAIN;
      end
    end
  end

  // FIFO pointer/count next-state; redirect flushes the buffer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (bus.redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC & PC_MASK;
      fetch_pc_q <= RESET_PC & PC_MASK;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Instruction buffer storage; contents are qualified by count so no reset needed
  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_resp_data;
    end
  end

endmodule
